rtl_kernel_wizard_1_example_chunk_sequencer: RTL and testbench

RTL_KERNEL_WIZARD_1_EXAMPLE_CHUNK_SEQUENCER -- requirements
Module: rtl_kernel_wizard_1_example_chunk_sequencer

---
 rtl/rtl_kernel_wizard_1_example_pkg.sv | 16 +
 rtl/rtl_kernel_wizard_1_example_chunk_sequencer.sv | 172 +++++++++++++++++
 tb/tb_rtl_kernel_wizard_1_example_chunk_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rtl_kernel_wizard_1_example_pkg.sv
// Shared definitions for the rtl_kernel_wizard_1_example blocks.
//   LP_DW_BYTES : bytes per core data beat at the default 512-bit data width;
//                 job and chunk sizes must be whole multiples of it.
//   seq_state_e : chunk sequencer FSM state encoding.
package rtl_kernel_wizard_1_example_pkg;

   localparam int LP_DW_BYTES = 512 / 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_e;

endpackage

// File: rtl/rtl_kernel_wizard_1_example_chunk_sequencer.sv
// Chunk sequencer: sits between the host control registers and the vadd core.
// It splits one host job (base address, total bytes) into core runs of at
// most ctrl_chunk_bytes each, and reports one ap_done when every run is done.
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   ap_start / ap_done       host job request (level) / job-complete pulse
//   ap_idle                  high while the sequencer is in IDLE
//   ctrl_*                   job base address, total bytes, max bytes per run
//   core_start / core_done   per-chunk start pulse / completion pulse
//   core_addr_offset         chunk base address (held from start to done)
//   core_xfer_size_in_bytes  chunk size (held from start to done)
//   chunk_count              chunks completed in the current or last job
//   cfg_error                last job rejected for a bad configuration
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for ap_start; ctrl inputs latched on acceptance
// ISSUE | core_start high this cycle (unless the job has nothing to run)
// WAIT  | chunk in flight, waiting for core_done
// DONE  | ap_done high this cycle; back to IDLE next
//
// Every output is registered and belongs to the state it is asserted in, so
// transitions also load the outputs the next state presents.
module rtl_kernel_wizard_1_example_chunk_sequencer
   import rtl_kernel_wizard_1_example_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = 64,
   parameter int C_M_AXI_DATA_WIDTH = LP_DW_BYTES * 8,
   parameter int C_XFER_SIZE_WIDTH  = 32
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic                          ap_start,
   output logic                          ap_done,
   output logic                          ap_idle,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
   input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
   input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_chunk_bytes,
   output logic                          core_start,
   input  logic                          core_done,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] core_addr_offset,
   output logic [C_XFER_SIZE_WIDTH-1:0]  core_xfer_size_in_bytes,
   output logic [C_XFER_SIZE_WIDTH-1:0]  chunk_count,
   output logic                          cfg_error
);

   localparam int LP_ALIGN = C_M_AXI_DATA_WIDTH / 8;
   // Data width is a power of two, so alignment is a mask test.
   localparam logic [C_XFER_SIZE_WIDTH-1:0] LP_ALIGN_MASK = C_XFER_SIZE_WIDTH'(LP_ALIGN - 1);

   seq_state_e                    state_q;
   logic [C_M_AXI_ADDR_WIDTH-1:0] base_q;
   logic [C_XFER_SIZE_WIDTH-1:0]  chunk_q;
   logic [C_XFER_SIZE_WIDTH-1:0]  remaining_q;
   logic [C_XFER_SIZE_WIDTH-1:0]  done_bytes_q;
   logic                          ap_done_q;
   logic                          ap_idle_q;
   logic                          core_start_q;
   logic [C_M_AXI_ADDR_WIDTH-1:0] core_addr_q;
   logic [C_XFER_SIZE_WIDTH-1:0]  core_size_q;
   logic [C_XFER_SIZE_WIDTH-1:0]  chunk_count_q;
   logic                          cfg_error_q;

   logic                          job_empty_d;
   logic                          job_bad_d;
   logic [C_XFER_SIZE_WIDTH-1:0]  first_size_d;
   logic [C_XFER_SIZE_WIDTH-1:0]  rem_after_d;
   logic [C_XFER_SIZE_WIDTH-1:0]  done_after_d;
   logic [C_XFER_SIZE_WIDTH-1:0]  next_size_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0] next_addr_d;

   always_comb begin
      // An empty job is a clean no-op, checked before the config sanity test.
      job_empty_d  = (ctrl_xfer_size_in_bytes == '0);
      job_bad_d    = (ctrl_chunk_bytes == '0)
                     || ((ctrl_xfer_size_in_bytes & LP_ALIGN_MASK) != '0)
                     || ((ctrl_chunk_bytes & LP_ALIGN_MASK) != '0);
      first_size_d = (ctrl_xfer_size_in_bytes < ctrl_chunk_bytes) ?
                     ctrl_xfer_size_in_bytes : ctrl_chunk_bytes;
      // Saturate so a corrupted size can never wrap the remaining count.
      rem_after_d  = (core_size_q > remaining_q) ? '0 : (remaining_q - core_size_q);
      done_after_d = done_bytes_q + core_size_q;
      next_size_d  = (rem_after_d < chunk_q) ? rem_after_d : chunk_q;
      // Address wraps modulo 2^C_M_AXI_ADDR_WIDTH by plain truncation.
      next_addr_d  = base_q + C_M_AXI_ADDR_WIDTH'(done_after_d);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q       <= ST_IDLE;
         base_q        <= '0;
         chunk_q       <= '0;
         remaining_q   <= '0;
         done_bytes_q  <= '0;
         ap_done_q     <= 1'b0;
         ap_idle_q     <= 1'b1;
         core_start_q  <= 1'b0;
         core_addr_q   <= '0;
         core_size_q   <= '0;
         chunk_count_q <= '0;
         cfg_error_q   <= 1'b0;
      end else begin
         ap_done_q    <= 1'b0;
         core_start_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (ap_start) begin
                  state_q       <= ST_ISSUE;
                  ap_idle_q     <= 1'b0;
                  base_q        <= ctrl_addr_offset;
                  chunk_q       <= ctrl_chunk_bytes;
                  done_bytes_q  <= '0;
                  chunk_count_q <= '0;
                  if (job_empty_d || job_bad_d) begin
                     // Zero remaining makes ISSUE fall straight through to DONE.
                     remaining_q <= '0;
                     cfg_error_q <= !job_empty_d;
                  end else begin
                     remaining_q  <= ctrl_xfer_size_in_bytes;
                     cfg_error_q  <= 1'b0;
                     core_start_q <= 1'b1;
                     core_size_q  <= first_size_d;
                     core_addr_q  <= ctrl_addr_offset;
                  end
               end
            end
            ST_ISSUE: begin
               if (remaining_q == '0) begin
                  state_q   <= ST_DONE;
                  ap_done_q <= 1'b1;
               end else begin
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (core_done) begin
                  done_bytes_q  <= done_after_d;
                  remaining_q   <= rem_after_d;
                  chunk_count_q <= chunk_count_q + 1'b1;
                  if (rem_after_d == '0) begin
                     state_q   <= ST_DONE;
                     ap_done_q <= 1'b1;
                  end else begin
                     state_q      <= ST_ISSUE;
                     core_start_q <= 1'b1;
                     core_size_q  <= next_size_d;
                     core_addr_q  <= next_addr_d;
                  end
               end
            end
            ST_DONE: begin
               state_q   <= ST_IDLE;
               ap_idle_q <= 1'b1;
            end
            default: begin
               state_q   <= ST_IDLE;
               ap_idle_q <= 1'b1;
            end
         endcase
      end
   end

   assign ap_done                 = ap_done_q;
   assign ap_idle                 = ap_idle_q;
   assign core_start              = core_start_q;
   assign core_addr_offset        = core_addr_q;
   assign core_xfer_size_in_bytes = core_size_q;
   assign chunk_count             = chunk_count_q;
   assign cfg_error               = cfg_error_q;

endmodule

// File: tb/tb_rtl_kernel_wizard_1_example_chunk_sequencer.sv
// Self-checking bench for the chunk sequencer: a table of directed jobs,
// a reset-mid-job sequence, then randomized jobs against a queue-based model
// of the expected chunk list.
module tb_rtl_kernel_wizard_1_example_chunk_sequencer;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        ap_start = 1'b0;
   logic        ap_done;
   logic        ap_idle;
   logic [63:0] ctrl_addr_offset = '0;
   logic [31:0] ctrl_xfer_size_in_bytes = '0;
   logic [31:0] ctrl_chunk_bytes = '0;
   logic        core_start;
   logic        core_done = 1'b0;
   logic [63:0] core_addr_offset;
   logic [31:0] core_xfer_size_in_bytes;
   logic [31:0] chunk_count;
   logic        cfg_error;

   int checks = 0;
   int errors = 0;

   rtl_kernel_wizard_1_example_chunk_sequencer dut (
      .aclk                    (aclk),
      .aresetn                 (aresetn),
      .ap_start                (ap_start),
      .ap_done                 (ap_done),
      .ap_idle                 (ap_idle),
      .ctrl_addr_offset        (ctrl_addr_offset),
      .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
      .ctrl_chunk_bytes        (ctrl_chunk_bytes),
      .core_start              (core_start),
      .core_done               (core_done),
      .core_addr_offset        (core_addr_offset),
      .core_xfer_size_in_bytes (core_xfer_size_in_bytes),
      .chunk_count             (chunk_count),
      .cfg_error               (cfg_error)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_ap_done"},    ap_done, 0);
      chk({tag, "_ap_idle"},    ap_idle, 1);
      chk({tag, "_core_start"}, core_start, 0);
      chk({tag, "_cfg_error"},  cfg_error, 0);
      chk({tag, "_addr"},       core_addr_offset, 0);
      chk({tag, "_size"},       core_xfer_size_in_bytes, 0);
      chk({tag, "_count"},      chunk_count, 0);
   endtask

   // Runs one job starting at the current negedge. Expected chunk list comes
   // from plain arithmetic on (base, total, chunk). The core responds lat
   // cycles after each core_start. spur adds core_done pulses while the
   // sequencer is IDLE/ISSUE; hold keeps ap_start high with scrambled ctrl
   // inputs for the whole job.
   task automatic run_job(input logic [63:0] base, input logic [31:0] total,
                          input logic [31:0] chunk, input int lat,
                          input bit spur, input bit hold,
                          output int obs_count, output bit obs_err,
                          output logic [63:0] last_addr, output logic [31:0] last_size);
      logic [63:0] q_addr[$];
      logic [31:0] q_size[$];
      longint      rem, off, sz;
      bit          exp_err;
      int          exp_n, cnt, exp_next;
      bit          seen_done;

      exp_err = 1'b0;
      if (total != 0) begin
         if (chunk == 0 || (total % 64) != 0 || (chunk % 64) != 0) begin
            exp_err = 1'b1;
         end else begin
            rem = total;
            off = 0;
            while (rem > 0) begin
               sz = (rem < chunk) ? rem : longint'(chunk);
               q_addr.push_back(base + 64'(off));
               q_size.push_back(32'(sz));
               off += sz;
               rem -= sz;
            end
         end
      end
      exp_n     = q_size.size();
      last_addr = '0;
      last_size = '0;
      cnt       = 0;
      exp_next  = 1;
      seen_done = 1'b0;

      ctrl_addr_offset        = base;
      ctrl_xfer_size_in_bytes = total;
      ctrl_chunk_bytes        = chunk;
      ap_start                = 1'b1;
      core_done               = spur;

      for (int k = 1; k <= 600 && !seen_done; k++) begin
         @(negedge aclk);
         core_done = 1'b0;
         if (hold) begin
            ctrl_addr_offset        = {$urandom(), $urandom()};
            ctrl_xfer_size_in_bytes = $urandom();
            ctrl_chunk_bytes        = $urandom();
         end else begin
            ap_start = 1'b0;
         end
         if (k == 1) chk("busy_not_idle", ap_idle, 0);
         if (core_start) begin
            chk("start_cycle", k, exp_next);
            if (q_addr.size() == 0) begin
               chk("unexpected_core_start", core_start, 0);
            end else begin
               chk("chunk_addr", core_addr_offset, q_addr.pop_front());
               chk("chunk_size", core_xfer_size_in_bytes, q_size.pop_front());
            end
            last_addr = core_addr_offset;
            last_size = core_xfer_size_in_bytes;
            cnt       = lat;
            if (spur) core_done = 1'b1;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               core_done = 1'b1;
               exp_next  = k + 1;
            end
         end
         if (ap_done) begin
            seen_done = 1'b1;
            chk("done_cycle", k, (exp_n == 0) ? 2 : exp_next);
            chk("chunks_left", q_addr.size(), 0);
            chk("chunk_count", chunk_count, exp_n);
            chk("cfg_error", cfg_error, exp_err);
            obs_count = chunk_count;
            obs_err   = cfg_error;
            ap_start  = 1'b0;
            core_done = 1'b0;
         end
      end
      if (!seen_done) begin
         chk("ap_done_timeout", seen_done, 1);
         obs_count = -1;
         obs_err   = 1'b0;
      end
      ap_start  = 1'b0;
      core_done = 1'b0;
      @(negedge aclk);
      chk("single_ap_done", ap_done, 0);
      chk("back_to_idle", ap_idle, 1);
      chk("cfg_error_held", cfg_error, exp_err);
   endtask

   typedef struct {
      logic [63:0] base;
      logic [31:0] total;
      logic [31:0] chunk;
      int          lat;
      bit          spur;
      bit          hold;
      int          exp_chunks;
      bit          exp_err;
      logic [63:0] exp_last_addr;
      logic [31:0] exp_last_size;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int          n;
      bit          e;
      logic [63:0] la;
      logic [31:0] ls;
      logic [63:0] rbase;
      logic [31:0] rtot, rchk;
      bit          found;

      tbl[0] = '{64'h1000, 32'd4096, 32'd1024, 5, 1'b0, 1'b0, 4, 1'b0, 64'h1C00, 32'd1024};
      tbl[1] = '{64'h2000, 32'd1216, 32'd512,  3, 1'b0, 1'b0, 3, 1'b0, 64'h2400, 32'd192};
      tbl[2] = '{64'h3000, 32'd0,    32'd1024, 2, 1'b0, 1'b0, 0, 1'b0, 64'h0,    32'd0};
      tbl[3] = '{64'h3000, 32'd4096, 32'd100,  2, 1'b0, 1'b0, 0, 1'b1, 64'h0,    32'd0};
      tbl[4] = '{64'h4000, 32'd2048, 32'd1024, 4, 1'b1, 1'b1, 2, 1'b0, 64'h4400, 32'd1024};
      tbl[5] = '{64'hFFFF_FFFF_FFFF_FC00, 32'd2048, 32'd1024, 3, 1'b0, 1'b0, 2, 1'b0, 64'h0, 32'd1024};
      tbl[6] = '{64'h5000, 32'd1024, 32'd0,    2, 1'b0, 1'b0, 0, 1'b1, 64'h0,    32'd0};
      tbl[7] = '{64'h6000, 32'd100,  32'd64,   2, 1'b0, 1'b0, 0, 1'b1, 64'h0,    32'd0};
      tbl[8] = '{64'h7040, 32'd64,   32'd4096, 1, 1'b1, 1'b0, 1, 1'b0, 64'h7040, 32'd64};

      // Reset state, then release on a negedge and start the first job at once.
      repeat (2) @(negedge aclk);
      chk_reset_values("reset");
      aresetn = 1'b1;

      foreach (tbl[i]) begin
         run_job(tbl[i].base, tbl[i].total, tbl[i].chunk, tbl[i].lat,
                 tbl[i].spur, tbl[i].hold, n, e, la, ls);
         chk($sformatf("tbl%0d_count", i), n, tbl[i].exp_chunks);
         chk($sformatf("tbl%0d_err", i), e, tbl[i].exp_err);
         if (tbl[i].exp_chunks > 0) begin
            chk($sformatf("tbl%0d_last_addr", i), la, tbl[i].exp_last_addr);
            chk($sformatf("tbl%0d_last_size", i), ls, tbl[i].exp_last_size);
         end
      end

      // Reset asserted while chunk 2 is in flight.
      ctrl_addr_offset        = 64'h5000;
      ctrl_xfer_size_in_bytes = 32'd4096;
      ctrl_chunk_bytes        = 32'd1024;
      ap_start                = 1'b1;
      @(negedge aclk);
      ap_start = 1'b0;
      chk("rst_seq_first_start", core_start, 1);
      repeat (2) @(negedge aclk);
      core_done = 1'b1;
      @(negedge aclk);
      core_done = 1'b0;
      chk("rst_seq_second_start", core_start, 1);
      chk("rst_seq_second_addr", core_addr_offset, 64'h5400);
      repeat (2) @(negedge aclk);
      chk("rst_seq_count_before", chunk_count, 1);
      #2 aresetn = 1'b0;
      #1 chk_reset_values("async_reset");
      found = 1'b0;
      repeat (3) begin
         @(negedge aclk);
         if (ap_done) found = 1'b1;
      end
      chk("no_done_after_abort", found, 0);
      aresetn = 1'b1;
      run_job(64'h8000, 32'd1216, 32'd512, 2, 1'b0, 1'b0, n, e, la, ls);
      chk("post_reset_count", n, 3);

      // Randomized jobs; run_job compares every chunk against the model.
      for (int r = 0; r < 25; r++) begin
         rbase = {$urandom(), $urandom()};
         rtot  = 32'(64 * $urandom_range(0, 12));
         rchk  = 32'(64 * $urandom_range(1, 6));
         if ($urandom_range(0, 7) == 0) rchk = rchk + 32'd32;
         if ($urandom_range(0, 15) == 0) rchk = '0;
         if ($urandom_range(0, 15) == 0) rtot = rtot + 32'd16;
         run_job(rbase, rtot, rchk, $urandom_range(1, 6),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n, e, la, ls);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
